div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 21 ++
 rtl/div_unit.sv | 158 +++++++++++++++
 tb/tb_div_unit.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared core defines used by the divider: register bus widths, the
// M-extension funct3 codes for the divide/remainder instructions, and a
// small two's-complement magnitude helper.
package div_unit_pkg;

    localparam int REG_BUS      = 32;
    localparam int REG_ADDR_BUS = 5;

    // funct3 encodings. Bit 0 set means unsigned, bit 1 set means remainder.
    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    // Magnitude of a two's-complement value. 0x80000000 maps to itself,
    // which the unsigned datapath then treats as 2^31.
    function automatic logic [REG_BUS-1:0] abs_val(input logic [REG_BUS-1:0] v);
        return v[REG_BUS-1] ? -v : v;
    endfunction

endpackage

// File: rtl/div_unit.sv
// div_unit -- multi-cycle restoring divider for DIV/DIVU/REM/REMU.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   start_i      request a division (sampled only in IDLE)
//   abort_i      cancel the in-flight operation; beats start_i
//   op_i         funct3 of the instruction
//   dividend_i   rs1 value
//   divisor_i    rs2 value
//   reg_waddr_i  destination register, returned with the result
//   busy_o       high whenever the FSM is not in IDLE
//   ready_o      one-cycle pulse; result_o/reg_waddr_o valid only then
//   result_o     quotient or remainder, zero outside the ready cycle
//   reg_waddr_o  captured destination register, zero outside the ready cycle
//
// Timeline with start sampled at edge k: START at k+1, 32 CALC steps on
// edges k+2..k+33, END drives the result out at edge k+34. A zero divisor
// skips CALC, so the result appears at edge k+2.
module div_unit
    import div_unit_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [2:0]              op_i,
    input  logic [REG_BUS-1:0]      dividend_i,
    input  logic [REG_BUS-1:0]      divisor_i,
    input  logic [REG_ADDR_BUS-1:0] reg_waddr_i,
    output logic                    busy_o,
    output logic                    ready_o,
    output logic [REG_BUS-1:0]      result_o,
    output logic [REG_ADDR_BUS-1:0] reg_waddr_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] CALC  = 2'd2;
    localparam logic [1:0] END   = 2'd3;

    logic [1:0]              state;
    logic [4:0]              count;
    logic [2:0]              op_q;
    logic [REG_BUS-1:0]      dividend_q;
    logic [REG_BUS-1:0]      divisor_q;
    logic [REG_ADDR_BUS-1:0] waddr_q;
    logic [REG_BUS-1:0]      dvs;   // divisor magnitude used by the steps
    logic [REG_BUS-1:0]      quo;   // dividend shifting out, quotient shifting in
    logic [REG_BUS-1:0]      rem;   // partial remainder

    logic accept;
    logic signed_op;
    logic rem_op;
    logic div_zero;

    assign busy_o    = (state != IDLE);
    assign accept    = (state == IDLE) && start_i && !abort_i;
    assign signed_op = ~op_q[0];
    assign rem_op    = op_q[1];
    assign div_zero  = (divisor_q == '0);

    // One restoring step. The shifted remainder needs 33 bits because it
    // can reach 2*dvs-1 before the trial subtraction.
    logic [REG_BUS:0]   shifted;
    logic [REG_BUS:0]   trial;
    logic               fits;
    logic [REG_BUS-1:0] rem_next;
    logic [REG_BUS-1:0] quo_next;

    always_comb begin
        shifted  = {rem, quo[REG_BUS-1]};
        trial    = shifted - {1'b0, dvs};
        fits     = (shifted >= {1'b0, dvs});
        rem_next = fits ? trial[REG_BUS-1:0] : shifted[REG_BUS-1:0];
        quo_next = {quo[REG_BUS-2:0], fits};
    end

    // Sign fix-up and divide-by-zero override, consumed in END.
    logic [REG_BUS-1:0] q_fix;
    logic [REG_BUS-1:0] r_fix;
    logic [REG_BUS-1:0] final_res;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        q_fix = quo;
        r_fix = rem;
        if (div_zero) begin
            q_fix = '1;
            r_fix = dividend_q;
        end else if (signed_op) begin
            if (dividend_q[REG_BUS-1] ^ divisor_q[REG_BUS-1]) q_fix = -quo;
            if (dividend_q[REG_BUS-1])                        r_fix = -rem;
        end
        final_res = rem_op ? r_fix : q_fix;
    end

    // Control path and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            count       <= '0;
            ready_o     <= 1'b0;
            result_o    <= '0;
            reg_waddr_o <= '0;
        end else begin
            ready_o     <= 1'b0;
            result_o    <= '0;
            reg_waddr_o <= '0;
            if (abort_i && state != IDLE) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE:  if (accept) state <= START;
                    START: begin
                        count <= '0;
                        state <= div_zero ? END : CALC;
                    end
                    CALC: begin
                        count <= count + 5'd1;
                        if (count == 5'd31) state <= END;
                    end
                    END: begin
                        state       <= IDLE;
                        ready_o     <= 1'b1;
                        result_o    <= final_res;
                        reg_waddr_o <= waddr_q;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Datapath registers.
    // NOTE: these are deliberately not reset; each is loaded before it is
    // used, and the outputs are gated to zero by the control block.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q       <= op_i;
            dividend_q <= dividend_i;
            divisor_q  <= divisor_i;
            waddr_q    <= reg_waddr_i;
        end
        if (state == START) begin
            quo <= signed_op ? abs_val(dividend_q) : dividend_q;
            dvs <= signed_op ? abs_val(divisor_q)  : divisor_q;
            rem <= '0;
        end else if (state == CALC) begin
            quo <= quo_next;
            rem <= rem_next;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed spec examples, randomized
// operations against an arithmetic reference model, busy/abort/reset and
// back-to-back scenarios. Outputs are sampled on the falling clock edge.
module tb_div_unit;
    import div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  waddr = '0;
    logic        busy;
    logic        ready;
    logic [31:0] result;
    logic [4:0]  waddr_out;

    int checks = 0;
    int errors = 0;

    div_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .abort_i     (abort),
        .op_i        (op),
        .dividend_i  (a),
        .divisor_i   (b),
        .reg_waddr_i (waddr),
        .busy_o      (busy),
        .ready_o     (ready),
        .result_o    (result),
        .reg_waddr_o (waddr_out)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic plus the RISC-V special cases.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x,
                                          input logic [31:0] y);
        logic [31:0] q;
        logic [31:0] r;
        if (y == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = x;
        end else if (!f[0]) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
            end
        end else begin
            q = x / y;
            r = x % y;
        end
        return f[1] ? r : q;
    endfunction

    // Issue one operation (caller is at a falling edge), then follow it to
    // its ready pulse checking latency, busy profile, result and the zeroed
    // outputs in the cycle after.
    task automatic do_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] w, input logic [31:0] exp_res, input string tag);
        int exp_lat;
        int lat;
        int busy_bad;
        exp_lat  = (y == 32'd0) ? 2 : 34;
        lat      = 0;
        busy_bad = 0;
        op = f; a = x; b = y; waddr = w; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start: got %b want 1", tag, busy);
        end
        for (int n = 1; n <= 60 && lat == 0; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready === 1'b1) begin
                lat = n;
                if (busy !== 1'b0) busy_bad++;
            end else if (busy !== 1'b1) begin
                busy_bad++;
            end
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat);
        end
        checks++;
        if (result !== exp_res) begin
            errors++;
            $display("FAIL %s result: got %h want %h (op %b a %h b %h)", tag, result, exp_res, f, x, y);
        end
        checks++;
        if (waddr_out !== w) begin
            errors++;
            $display("FAIL %s waddr: got %0d want %0d", tag, waddr_out, w);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL %s busy_profile: got %0d bad cycles want 0", tag, busy_bad);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready !== 1'b0 || result !== 32'd0 || waddr_out !== 5'd0) begin
            errors++;
            $display("FAIL %s idle_outputs: got ready %b result %h waddr %0d want 0 0 0",
                     tag, ready, result, waddr_out);
        end
    endtask

    // Watch a number of cycles and report whether any ready pulse appeared.
    task automatic watch_no_ready(input int cycles, input string tag);
        int seen;
        seen = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (ready !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL %s no_ready: got %0d pulses want 0", tag, seen);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0 || result !== 32'd0 || waddr_out !== 5'd0) begin
            errors++;
            $display("FAIL reset_state: got busy %b ready %b result %h waddr %0d want all 0",
                     busy, ready, result, waddr_out);
        end
        // First edge with rst high must already accept a start.
        rst = 1'b1;
        do_op(INST_DIV, 32'd100, 32'd7, 5'd1, 32'd14, "div_100_7");
    endtask

    task automatic test_directed;
        do_op(INST_REM,  32'hFFFF_FFF9, 32'd2,  5'd2,  32'hFFFF_FFFF, "rem_m7_2");
        do_op(INST_DIV,  32'hFFFF_FFF9, 32'd2,  5'd3,  32'hFFFF_FFFD, "div_m7_2");
        do_op(INST_REMU, 32'hFFFF_FFFF, 32'd16, 5'd4,  32'd15,        "remu_big_16");
        do_op(INST_DIVU, 32'd5,         32'd0,  5'd5,  32'hFFFF_FFFF, "divu_5_0");
        do_op(INST_REM,  32'd5,         32'd0,  5'd6,  32'd5,         "rem_5_0");
        do_op(INST_DIV,  32'hFFFF_FFF9, 32'd0,  5'd7,  32'hFFFF_FFFF, "div_m7_0");
        do_op(INST_REM,  32'hFFFF_FFF9, 32'd0,  5'd8,  32'hFFFF_FFF9, "rem_m7_0");
        do_op(INST_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h8000_0000, "div_ovf");
        do_op(INST_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0,         "rem_ovf");
    endtask

    task automatic test_random;
        logic [2:0]  f;
        logic [31:0] x;
        logic [31:0] y;
        for (int i = 0; i < 30; i++) begin
            f = INST_DIV + 3'($urandom_range(0, 3));
            x = $urandom;
            case ($urandom_range(0, 5))
                0:       y = 32'd0;
                1:       y = 32'($urandom_range(1, 15));
                2:       y = -32'($urandom_range(1, 15));
                3:       y = $urandom >> $urandom_range(0, 31);
                default: y = $urandom;
            endcase
            do_op(f, x, y, 5'($urandom_range(0, 31)), model(f, x, y), "random");
        end
    endtask

    // A start while busy must neither disturb the running op nor be queued.
    task automatic test_busy_ignore;
        int lat;
        lat = 0;
        op = INST_DIVU; a = 32'd1000; b = 32'd9; waddr = 5'd11; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        op = INST_REM; a = 32'd77; b = 32'd0; waddr = 5'd12; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 6; n <= 60 && lat == 0; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready === 1'b1) lat = n;
        end
        checks++;
        if (lat != 34 || result !== 32'd111 || waddr_out !== 5'd11) begin
            errors++;
            $display("FAIL busy_ignore: got lat %0d result %h waddr %0d want 34 0000006f 11",
                     lat, result, waddr_out);
        end
        watch_no_ready(40, "busy_ignore_no_queue");
    endtask

    task automatic test_abort;
        op = INST_DIV; a = 32'd1000; b = 32'd3; waddr = 5'd13; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy_before: got %b want 1", busy);
        end
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy_after: got %b want 0", busy);
        end
        watch_no_ready(40, "abort");
        do_op(INST_DIV, 32'd1000, 32'd3, 5'd14, 32'd333, "after_abort");
        // Abort beats start in the same cycle.
        start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_priority: got busy %b want 0", busy);
        end
    endtask

    // start held high: the second op is accepted on the edge closing the
    // first ready cycle and completes 34 edges after that.
    task automatic test_back_to_back;
        int lat1;
        int lat2;
        lat1 = 0;
        lat2 = 0;
        op = INST_DIV; a = 32'd1000; b = 32'd10; waddr = 5'd3; start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 60 && lat1 == 0; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready === 1'b1) lat1 = n;
        end
        checks++;
        if (lat1 != 34 || result !== 32'd100) begin
            errors++;
            $display("FAIL b2b_first: got lat %0d result %h want 34 00000064", lat1, result);
        end
        op = INST_REMU; a = 32'hFFFF_FFFF; b = 32'd16; waddr = 5'd9;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 60 && lat2 == 0; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready === 1'b1) lat2 = n;
        end
        checks++;
        if (lat2 != 34 || result !== 32'd15 || waddr_out !== 5'd9) begin
            errors++;
            $display("FAIL b2b_second: got lat %0d result %h waddr %0d want 34 0000000f 9",
                     lat2, result, waddr_out);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_third: got busy %b want 0", busy);
        end
    endtask

    task automatic test_reset_mid;
        op = INST_DIV; a = 32'd500; b = 32'd7; waddr = 5'd20; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0 || result !== 32'd0 || waddr_out !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid: got busy %b ready %b result %h waddr %0d want all 0",
                     busy, ready, result, waddr_out);
        end
        rst = 1'b1;
        watch_no_ready(40, "reset_mid");
        do_op(INST_DIVU, 32'd500, 32'd7, 5'd21, 32'd71, "after_reset");
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_busy_ignore;
        test_abort;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
